// File: rtl/pulse_regen.sv
// Regenerates single-cycle event strobes as spaced level pulses (HIGH_CYCLES high,
// at least LOW_CYCLES low), queueing strobes that arrive mid-pulse.
module pulse_regen #(
    parameter int unsigned HIGH_CYCLES = 4,
    parameter int unsigned LOW_CYCLES  = 4,
    parameter int unsigned PEND_W      = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
);

    localparam int unsigned MAX_PHASE = (HIGH_CYCLES > LOW_CYCLES) ? HIGH_CYCLES : LOW_CYCLES;
    localparam int unsigned CNT_W     = $clog2(MAX_PHASE + 1);
    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_CYCLES - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [PEND_W-1:0]   r_pend;
    logic [PEND_W-1:0]   w_pend_nxt;
    logic                r_ovf;
    logic                w_ovf_nxt;
    logic                r_out;
    logic                r_busy;

    // Next-state, phase counter and pending-queue bookkeeping
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + CNT_W'(1);
        w_pend_nxt  = r_pend;
        w_ovf_nxt   = r_ovf;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (in) begin
                    w_state_nxt = HIGH;
                end
            end
            HIGH: begin
                if (r_cnt == HIGH_LAST) begin
                    w_state_nxt = LOW;
                    w_cnt_nxt   = '0;
                end
                if (in) begin
                    if (r_pend == PEND_MAX) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = r_pend + PEND_W'(1);
                    end
                end
            end
            LOW: begin
                if (r_cnt == LOW_LAST) begin
                    w_cnt_nxt = '0;
                    // A strobe on the final low edge starts the next period directly,
                    // so IDLE never holds a non-zero queue.
                    if ((r_pend != '0) || in) begin
                        w_state_nxt = HIGH;
                        if (!in) begin
                            w_pend_nxt = r_pend - PEND_W'(1);
                        end
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (in) begin
                    if (r_pend == PEND_MAX) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_pend_nxt = r_pend + PEND_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
            r_out   <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
            r_out   <= (w_state_nxt == HIGH);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

    assign out      = r_out;
    assign busy     = r_busy;
    assign pending  = r_pend;
    assign overflow = r_ovf;

endmodule

// File: doc/pulse_regen.md
Name: pulse_regen

Overview:
- Inverse companion of the calculator's edge detector: turns single-cycle strobes (key/op events) back into clean, spaced level pulses.
- Each input strobe produces exactly one output high period followed by a guaranteed low gap, so a downstream `posedge_detect` recovers every event one-to-one.
- Strobes arriving while an output pulse is in progress are queued in a saturating pending counter.
- Sits between the control logic and display/LED or handshake outputs.

Parameters:
- HIGH_CYCLES, 4, cycles `out` is held high per event (>=1).
- LOW_CYCLES, 4, minimum cycles `out` is held low after each high period (>=1).
- PEND_W, 3, width of pending counter; max queued events = 2^PEND_W-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- in  input  1  event strobe; every cycle sampled high counts as one event.
- out  output  1  regenerated pulse, registered.
- busy  output  1  high whenever state != IDLE.
- pending  output  PEND_W  queued events not yet started.
- overflow  output  1  sticky: an event was dropped because pending was saturated.

Behaviour:
- Single clock `clk`; reset `rst` is synchronous and active-high. On an `rst` edge: state=IDLE, out=0, busy=0, pending=0, overflow=0, internal counters=0. `in` is ignored on any edge where rst=1.
- Cycle n is the interval after rising edge n. All outputs are registered or decoded from registered state.
- FSM states: IDLE, HIGH, LOW. The phase counter is $clog2(max(HIGH_CYCLES,LOW_CYCLES)+1) bits and counts up from 0 in each phase.
- IDLE:
  - Edge with in=1 -> HIGH, out=1 from that cycle (latency 0 cycles after the sampling edge). pending is unchanged.
  - pending is always 0 in IDLE.
- HIGH: out=1 for exactly HIGH_CYCLES cycles, then -> LOW with out=0.
- LOW: out=0 for exactly LOW_CYCLES cycles. On the final LOW edge:
  - if pending>0 (value before this edge): -> HIGH, pending decrements.
  - else: -> IDLE.
- Event queueing (state != IDLE, or IDLE with a simultaneous start):
  - in=1 while in HIGH or LOW -> pending+1.
  - If pending is already 2^PEND_W-1 and no decrement happens on the same edge: the event is dropped, pending holds, overflow<=1.
  - Simultaneous increment and decrement on the final LOW edge: pending is unchanged, no overflow.
- overflow is cleared only by rst.
- busy=1 in HIGH and LOW; busy=0 in IDLE.
- Period per event = HIGH_CYCLES+LOW_CYCLES. Back-to-back events produce contiguous periods with no extra idle cycle.
- Reset mid-operation: any state aborts immediately. out drops at that edge and queued events are discarded.

Test Plan (defaults H=4, L=4, PEND_W=3):
- Reset with in=1 for 3 cycles -> out=0, busy=0, pending=0, overflow=0 throughout; no pulse after rst falls if in=0.
- Single strobe at edge 10 -> out=1 cycles 10-13, out=0 cycles 14-17 with busy=1, busy=0 from cycle 18, pending stays 0.
- Strobes at edges 10, 11, 12:
  - pending=1 after edge 11 and 2 after edge 12.
  - High periods start at cycles 10, 18, 26; pending=1 after edge 18 and 0 after edge 26.
  - busy=0 from cycle 34.
- in held high edges 10-19:
  - pending reaches 7 after edge 17 and stays 7 at edge 18 (simultaneous inc/dec).
  - overflow=1 after edge 19.
  - 9 total output pulses, last high period starting at cycle 74, busy=0 from cycle 82.
- Strobe at edge 10, rst=1 with in=1 at edge 12 -> out=0 from cycle 12, busy=0, pending=0, no further pulses.
- Loopback: feed `out` into `posedge_detect` with random strobes (<=7 queued) -> detector pulse count equals input strobe count, overflow=0.
